// File: rtl/alu_seq_pkg.sv
// Shared opcode constants, FSM state encoding and opcode legality check
// for the ALU operation sequencer.
package alu_seq_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SGT = 4'b1000;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SRL = 4'b1101;
  localparam logic [3:0] OP_SLL = 4'b1110;
  localparam logic [3:0] OP_SRA = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  function automatic logic op_is_legal(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT,
      OP_SGT, OP_NOR, OP_SRL, OP_SLL, OP_SRA: op_is_legal = 1'b1;
      default:                                op_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_cmd_reg.sv
// Holds the fields of the accepted command; loaded on the accept edge and
// held unchanged until the next accept.
module alu_seq_cmd_reg
  import alu_seq_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [3:0]    op_i,
  input  logic [AW-1:0] rs_i,
  input  logic [AW-1:0] rt_i,
  input  logic [AW-1:0] rd_i,
  input  logic [4:0]    shamt_i,
  input  logic          imm_sel_i,
  input  logic [DW-1:0] imm_i,
  output logic [3:0]    op_o,
  output logic [AW-1:0] rs_o,
  output logic [AW-1:0] rt_o,
  output logic [AW-1:0] rd_o,
  output logic [4:0]    shamt_o,
  output logic          imm_sel_o,
  output logic [DW-1:0] imm_o
);

  logic [3:0]    op_q;
  logic [AW-1:0] rs_q;
  logic [AW-1:0] rt_q;
  logic [AW-1:0] rd_q;
  logic [4:0]    shamt_q;
  logic          imm_sel_q;
  logic [DW-1:0] imm_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q      <= 4'd0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      shamt_q   <= 5'd0;
      imm_sel_q <= 1'b0;
      imm_q     <= '0;
    end else if (load_i) begin
      op_q      <= op_i;
      rs_q      <= rs_i;
      rt_q      <= rt_i;
      rd_q      <= rd_i;
      shamt_q   <= shamt_i;
      imm_sel_q <= imm_sel_i;
      imm_q     <= imm_i;
    end
  end

  assign op_o      = op_q;
  assign rs_o      = rs_q;
  assign rt_o      = rt_q;
  assign rd_o      = rd_q;
  assign shamt_o   = shamt_q;
  assign imm_sel_o = imm_sel_q;
  assign imm_o     = imm_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU/immediate command through READ, EXEC and WB, driving the
// register file, write-data mux and external ALU with registered controls.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5,
  parameter int unsigned CW = 16
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [AW-1:0] cmd_rs,
  input  logic [AW-1:0] cmd_rt,
  input  logic [AW-1:0] cmd_rd,
  input  logic [4:0]    cmd_shamt,
  input  logic          cmd_imm_sel,
  input  logic [DW-1:0] cmd_imm,
  output logic [AW-1:0] RR1,
  output logic [AW-1:0] RR2,
  output logic [3:0]    ALUOp,
  output logic [4:0]    ShiftCount,
  input  logic [DW-1:0] alu_result,
  output logic          MuxSel,
  output logic [DW-1:0] WD,
  output logic [AW-1:0] WR,
  output logic          WE,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] result,
  output logic [CW-1:0] retired
);

  state_e        state_q;
  logic          ready_q;
  logic          we_q;
  logic          done_q;
  logic          err_q;
  logic          mux_q;
  logic [DW-1:0] wd_q;
  logic [DW-1:0] alu_q;
  logic [DW-1:0] result_q;
  logic [CW-1:0] retired_q;

  logic [3:0]    c_op;
  logic [AW-1:0] c_rs;
  logic [AW-1:0] c_rt;
  logic [AW-1:0] c_rd;
  logic [4:0]    c_shamt;
  logic          c_imm_sel;
  logic [DW-1:0] c_imm;

  logic          accept_c;
  logic          writes_c;
  logic [DW-1:0] result_d;
  logic [CW-1:0] retired_d;

  assign accept_c  = cmd_valid && ready_q && (state_q == ST_IDLE);
  // Immediate commands always write; ALU commands only with a legal opcode.
  assign writes_c  = c_imm_sel || op_is_legal(c_op);
  assign result_d  = c_imm_sel ? c_imm : alu_q;
  assign retired_d = retired_q + CW'(1);

  alu_seq_cmd_reg #(
    .DW (DW),
    .AW (AW)
  ) u_cmd_reg (
    .clk_i     (Clk),
    .rst_i     (Rst),
    .load_i    (accept_c),
    .op_i      (cmd_op),
    .rs_i      (cmd_rs),
    .rt_i      (cmd_rt),
    .rd_i      (cmd_rd),
    .shamt_i   (cmd_shamt),
    .imm_sel_i (cmd_imm_sel),
    .imm_i     (cmd_imm),
    .op_o      (c_op),
    .rs_o      (c_rs),
    .rt_o      (c_rt),
    .rd_o      (c_rd),
    .shamt_o   (c_shamt),
    .imm_sel_o (c_imm_sel),
    .imm_o     (c_imm)
  );

  // FSM with registered outputs; WB-phase controls are set on the EXEC edge.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b1;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      mux_q     <= 1'b0;
      wd_q      <= '0;
      alu_q     <= '0;
      result_q  <= '0;
      retired_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            state_q <= ST_READ;
            ready_q <= 1'b0;
          end
        end
        ST_READ: begin
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          state_q <= ST_WB;
          alu_q   <= alu_result;
          we_q    <= writes_c;
          done_q  <= 1'b1;
          err_q   <= !writes_c;
          mux_q   <= !c_imm_sel;
          wd_q    <= c_imm_sel ? c_imm : '0;
        end
        ST_WB: begin
          state_q   <= ST_IDLE;
          ready_q   <= 1'b1;
          we_q      <= 1'b0;
          done_q    <= 1'b0;
          err_q     <= 1'b0;
          mux_q     <= 1'b0;
          wd_q      <= '0;
          retired_q <= retired_d;
          if (writes_c) begin
            result_q <= result_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = ready_q;
  assign RR1        = c_rs;
  assign RR2        = c_rt;
  assign ALUOp      = c_op;
  assign ShiftCount = c_shamt;
  assign WR         = c_rd;
  assign WE         = we_q;
  assign done       = done_q;
  assign err        = err_q;
  assign MuxSel     = mux_q;
  assign WD         = wd_q;
  assign result     = result_q;
  assign retired    = retired_q;

endmodule
